// File: rtl/soup_farm.sv
// soup_farm: hands INIT x INIT soups to idle Life search cores and collects
// their life reports into a show-ahead result FIFO for the host.
module soup_farm #(
  parameter int INIT  = 20,
  parameter int NCORE = 4,
  parameter int DEPTH = 8,
  localparam int S    = INIT * INIT,
  localparam int R    = S + 64,
  localparam int CW   = (NCORE > 1) ? $clog2(NCORE) : 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               stop_on_life,
  input  logic               soup_valid,
  output logic               soup_ready,
  input  logic [S-1:0]       soup_data,
  output logic [NCORE-1:0]   core_run,
  output logic [S-1:0]       core_soup,
  input  logic [NCORE-1:0]   core_busy,
  input  logic [NCORE-1:0]   core_life,
  input  logic [NCORE*R-1:0] core_data,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [R-1:0]       res_data,
  output logic [CW-1:0]      res_core,
  output logic [31:0]        soup_count,
  output logic [15:0]        drop_count,
  output logic               halted
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_BUSY = 2'd2} st_t;

  st_t              r_st    [NCORE];
  st_t              w_st_nx [NCORE];
  logic [NCORE-1:0] w_idle;
  logic [CW-1:0]    r_rr, w_sel;
  logic             w_found, w_hs;
  logic [NCORE-1:0] r_run;
  logic [S-1:0]     r_soup;
  logic [31:0]      r_sc;
  logic [NCORE-1:0] r_pv;
  logic [R-1:0]     r_pend  [NCORE];
  logic [CW-1:0]    r_pp, w_psel;
  logic             w_pfound;
  logic [R-1:0]     r_mem   [DEPTH];
  logic [CW-1:0]    r_cmem  [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_full, w_push, w_pop;
  logic [CW:0]      w_ndrop;
  logic [15:0]      r_drop;
  logic             r_halt;

  // First requester at or after ptr, wrapping; returns {found, index}.
  function automatic logic [CW:0] rr_pick(input logic [NCORE-1:0] req, input logic [CW-1:0] ptr);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NCORE) idx = idx - NCORE;
      if (req[idx]) res = {1'b1, CW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
    return (p == CW'(NCORE - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lost-report counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign {w_found, w_sel}   = rr_pick(w_idle, r_rr);
  assign {w_pfound, w_psel} = rr_pick(r_pv, r_pp);

  assign soup_ready = reset & enable & ~r_halt & (|w_idle);
  assign w_hs       = soup_valid & soup_ready & w_found;

  assign w_full = (r_cnt == (AW + 1)'(DEPTH));
  assign w_pop  = res_valid & res_ready;
  assign w_push = w_pfound & (~w_full | w_pop);

  // Per-core state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCORE; k++) r_st[k] <= ST_IDLE;
    end else begin
      for (int k = 0; k < NCORE; k++) r_st[k] <= w_st_nx[k];
    end
  end

  // Per-core next state: an armed core waits to see its busy flag before it can return idle.
  always_comb begin
    for (int k = 0; k < NCORE; k++) begin
      w_st_nx[k] = r_st[k];
      case (r_st[k])
        ST_IDLE:  if (w_hs && (w_sel == CW'(k))) w_st_nx[k] = ST_ARMED;
        ST_ARMED: if (core_busy[k]) w_st_nx[k] = ST_BUSY;
        ST_BUSY:  if (!core_busy[k]) w_st_nx[k] = ST_IDLE;
        default:  w_st_nx[k] = ST_IDLE;
      endcase
    end
  end

  // Per-core output: which cores may take a new soup.
  always_comb begin
    for (int k = 0; k < NCORE; k++) w_idle[k] = (r_st[k] == ST_IDLE);
  end

  // Dispatch: register the soup, pulse the chosen core, advance the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run  <= '0;
      r_soup <= '0;
      r_rr   <= '0;
      r_sc   <= '0;
    end else begin
      r_run <= w_hs ? (NCORE'(1) << w_sel) : '0;
      if (w_hs) begin
        r_soup <= soup_data;
        r_rr   <= wrap_inc(w_sel);
        r_sc   <= r_sc + 32'd1;
      end
    end
  end

  // Pending-slot flags: capture into a free slot, free the slot being pushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pv   <= '0;
      r_pp   <= '0;
      r_drop <= '0;
    end else begin
      for (int k = 0; k < NCORE; k++) begin
        if (core_life[k] && !r_pv[k]) r_pv[k] <= 1'b1;
        else if (w_push && (w_psel == CW'(k))) r_pv[k] <= 1'b0;
      end
      if (w_push) r_pp <= wrap_inc(w_psel);
      r_drop <= sat_add16(r_drop, w_ndrop);
    end
  end

  // Reports arriving on an occupied slot are counted as lost.
  always_comb begin
    w_ndrop = '0;
    for (int k = 0; k < NCORE; k++) w_ndrop = w_ndrop + (CW + 1)'(core_life[k] & r_pv[k]);
  end

  // Pending report payloads.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCORE; k++) begin
      if (core_life[k] && !r_pv[k]) r_pend[k] <= core_data[k*R +: R];
    end
  end

  // FIFO storage: report and the index of the core that produced it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp]  <= r_pend[w_psel];
      r_cmem[r_wp] <= w_psel;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide at any fill level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Halt on the first push in stop mode; only a low enable releases it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_halt <= 1'b0;
    else if (!enable) r_halt <= 1'b0;
    else if (w_push && stop_on_life) r_halt <= 1'b1;
  end

  assign core_run   = r_run;
  assign core_soup  = r_soup;
  assign soup_count = r_sc;
  assign drop_count = r_drop;
  assign halted     = r_halt;
  assign res_valid  = (r_cnt != '0);
  assign res_data   = r_mem[r_rp];
  assign res_core   = res_valid ? r_cmem[r_rp] : '0;

endmodule

// File: tb/tb_soup_farm.sv
// Bench for soup_farm: emulated search cores plus a queue-based model of
// dispatch, report collection, drop accounting and halting.
module tb_soup_farm;
  localparam int INIT = 4, NCORE = 4, DEPTH = 8;
  localparam int S = INIT * INIT, R = S + 64;

  logic clk = 1'b0;
  logic reset, enable, stop_on_life, soup_valid, soup_ready, res_valid, res_ready, halted;
  logic [S-1:0] soup_data, core_soup;
  logic [NCORE-1:0] core_run, core_busy, core_life;
  logic [NCORE*R-1:0] core_data;
  logic [R-1:0] res_data;
  logic [1:0] res_core;
  logic [31:0] soup_count;
  logic [15:0] drop_count;

  int checks = 0, errors = 0;

  soup_farm #(.INIT(INIT), .NCORE(NCORE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .stop_on_life(stop_on_life),
    .soup_valid(soup_valid), .soup_ready(soup_ready), .soup_data(soup_data),
    .core_run(core_run), .core_soup(core_soup), .core_busy(core_busy),
    .core_life(core_life), .core_data(core_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_core(res_core),
    .soup_count(soup_count), .drop_count(drop_count), .halted(halted));

  always #5 clk = ~clk;

  // ---------------- reference model (0 idle, 1 armed, 2 busy) ----------------
  int m_st[NCORE];
  int m_rr, m_pp, m_drop;
  int unsigned m_sc;
  bit m_pv[NCORE];
  bit m_halt;
  logic [R-1:0] m_pend[NCORE];
  logic [S-1:0] m_soup;
  logic [NCORE-1:0] m_run;
  logic [R-1:0] q_d[$];
  int q_c[$];

  // emulated cores
  int bleft[NCORE];
  bit start_nx[NCORE];
  bit auto_life;
  int run_len;

  function automatic logic [R-1:0] rnd_rep();
    logic [R-1:0] v;
    for (int i = 0; i < R; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic bit m_ready();
    bit any_idle = 0;
    for (int c = 0; c < NCORE; c++) if (m_st[c] == 0) any_idle = 1;
    return reset && enable && !m_halt && any_idle;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCORE; c++) begin
      m_st[c] = 0; m_pv[c] = 0; m_pend[c] = '0;
    end
    m_rr = 0; m_pp = 0; m_drop = 0; m_sc = 0; m_halt = 0;
    m_soup = '0; m_run = '0;
    q_d.delete(); q_c.delete();
  endtask

  task automatic cores_clear();
    for (int c = 0; c < NCORE; c++) begin
      bleft[c] = 0; start_nx[c] = 0;
    end
    core_busy = '0; core_life = '0; core_data = '0;
  endtask

  // Apply the dispatcher rules for one clock edge using the inputs now on the pins.
  task automatic model_edge();
    bit rdy, pop, pushed;
    bit pv0[NCORE];
    int st0[NCORE];
    int k, c;
    rdy = m_ready();
    pv0 = m_pv;
    st0 = m_st;
    m_run = '0;
    if (soup_valid && rdy) begin
      k = -1;
      for (int i = 0; i < NCORE; i++) begin
        c = (m_rr + i) % NCORE;
        if (k < 0 && st0[c] == 0) k = c;
      end
      m_run[k] = 1'b1; m_soup = soup_data; m_rr = (k + 1) % NCORE; m_sc++; m_st[k] = 1;
    end
    for (int j = 0; j < NCORE; j++) begin
      if (st0[j] == 1 && core_busy[j]) m_st[j] = 2;
      else if (st0[j] == 2 && !core_busy[j]) m_st[j] = 0;
    end
    pop = (q_d.size() > 0) && res_ready;
    if (pop) begin q_d.delete(0); q_c.delete(0); end
    pushed = 0;
    if (q_d.size() < DEPTH) begin
      k = -1;
      for (int i = 0; i < NCORE; i++) begin
        c = (m_pp + i) % NCORE;
        if (k < 0 && pv0[c]) k = c;
      end
      if (k >= 0) begin
        q_d.push_back(m_pend[k]); q_c.push_back(k);
        m_pv[k] = 0; m_pp = (k + 1) % NCORE; pushed = 1;
      end
    end
    for (int j = 0; j < NCORE; j++) begin
      if (core_life[j]) begin
        if (pv0[j]) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          m_pend[j] = core_data[j*R +: R]; m_pv[j] = 1;
        end
      end
    end
    if (!enable) m_halt = 0;
    else if (pushed && stop_on_life) m_halt = 1;
  endtask

  // Emulated cores: busy starts the cycle after the run pulse and lasts run_len cycles.
  task automatic core_step();
    core_life = '0;
    for (int c = 0; c < NCORE; c++) begin
      if (core_busy[c]) begin
        if (bleft[c] == 0) begin
          core_busy[c] = 1'b0;
          if (auto_life) begin
            core_life[c] = 1'b1;
            core_data[c*R +: R] = rnd_rep();
          end
        end else bleft[c]--;
      end
      if (start_nx[c]) begin
        core_busy[c] = 1'b1; bleft[c] = run_len - 1;
      end
      start_nx[c] = core_run[c];
    end
  endtask

  task automatic tick();
    #1;
    model_edge();
    @(posedge clk);
    #1;
    core_step();
    soup_data = S'($urandom());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; stop_on_life = 1'b0; soup_valid = 1'b1; res_ready = 1'b0;
    soup_data = S'($urandom()); run_len = 10; auto_life = 0;
    cores_clear(); model_clear();
    @(posedge clk); #1;
    if (soup_ready !== 1'b0) begin errors++; $display("FAIL reset_soup_ready got=%0b want=0", soup_ready); end
    checks++;
    if (core_run !== '0) begin errors++; $display("FAIL reset_core_run got=%b want=0", core_run); end
    checks++;
    if (core_soup !== '0) begin errors++; $display("FAIL reset_core_soup got=%h want=0", core_soup); end
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0b want=0", res_valid); end
    checks++;
    if (res_core !== '0) begin errors++; $display("FAIL reset_res_core got=%0d want=0", res_core); end
    checks++;
    if (soup_count !== 32'd0) begin errors++; $display("FAIL reset_soup_count got=%0d want=0", soup_count); end
    checks++;
    if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got=%0d want=0", drop_count); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%0b want=0", halted); end
    checks++;
    reset = 1'b1;
  endtask

  task automatic test_dispatch();
    int order[$];
    logic [NCORE-1:0] prev;
    soup_valid = 1'b1; res_ready = 1'b1; run_len = 10; prev = '0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (soup_ready !== m_ready()) begin errors++; $display("FAIL disp_ready cyc=%0d got=%0b want=%0b", i, soup_ready, m_ready()); end
      checks++;
      tick();
      if (core_run !== m_run) begin errors++; $display("FAIL disp_core_run cyc=%0d got=%b want=%b", i, core_run, m_run); end
      checks++;
      if ((prev & core_run) !== '0) begin errors++; $display("FAIL disp_run_repeat cyc=%0d got=%b prev=%b", i, core_run, prev); end
      checks++;
      prev = core_run;
      for (int c = 0; c < NCORE; c++) if (core_run[c]) order.push_back(c);
      if (core_run != '0 && core_soup !== m_soup) begin errors++; $display("FAIL disp_core_soup got=%h want=%h", core_soup, m_soup); end
      checks++;
      if (soup_count !== m_sc) begin errors++; $display("FAIL disp_soup_count got=%0d want=%0d", soup_count, m_sc); end
      checks++;
      if (i == 5) begin
        if (soup_count !== 32'd4) begin errors++; $display("FAIL disp_count4 got=%0d want=4", soup_count); end
        checks++;
        if (soup_ready !== 1'b0) begin errors++; $display("FAIL disp_all_busy_ready got=%0b want=0", soup_ready); end
        checks++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      if (order.size() <= j || order[j] !== j) begin
        errors++; $display("FAIL disp_order idx=%0d got=%0d want=%0d", j, (order.size() > j) ? order[j] : -1, j);
      end
      checks++;
    end
    soup_valid = 1'b0;
    repeat (15) tick();
  endtask

  task automatic test_simul_life();
    logic [R-1:0] d1, d3;
    res_ready = 1'b1;
    d1 = rnd_rep(); d3 = rnd_rep();
    core_data[1*R +: R] = d1; core_data[3*R +: R] = d3;
    core_life = 4'b1010;
    tick();
    if (res_valid !== 1'b0) begin errors++; $display("FAIL life_early_valid got=%0b want=0", res_valid); end
    checks++;
    tick();
    if (res_valid !== 1'b1) begin errors++; $display("FAIL life_valid got=%0b want=1", res_valid); end
    checks++;
    if (res_core !== 2'd1 || res_data !== d1) begin errors++; $display("FAIL life_first got core=%0d data=%h want core=1 data=%h", res_core, res_data, d1); end
    checks++;
    tick();
    if (res_valid !== 1'b1 || res_core !== 2'd3 || res_data !== d3) begin
      errors++; $display("FAIL life_second got v=%0b core=%0d data=%h want v=1 core=3 data=%h", res_valid, res_core, res_data, d3);
    end
    checks++;
    tick();
    if (res_valid !== 1'b0) begin errors++; $display("FAIL life_empty got=%0b want=0", res_valid); end
    checks++;
  endtask

  task automatic test_backpressure();
    logic [R-1:0] exp_q[$];
    logic [R-1:0] v;
    int got, cyc;
    res_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = rnd_rep();
      exp_q.push_back(v);
      core_data[(i % 4)*R +: R] = v;
      core_life = NCORE'(1) << (i % 4);
      tick();
    end
    tick();
    if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin errors++; $display("FAIL bp_head got v=%0b data=%h want v=1 data=%h", res_valid, res_data, exp_q[0]); end
    checks++;
    if (q_d.size() !== DEPTH) begin errors++; $display("FAIL bp_model_fill got=%0d want=%0d", q_d.size(), DEPTH); end
    checks++;
    core_data[0 +: R] = rnd_rep();
    core_life = 4'b0001;
    tick();
    if (drop_count !== 16'd1) begin errors++; $display("FAIL bp_drop got=%0d want=1", drop_count); end
    checks++;
    res_ready = 1'b1;
    got = 0; cyc = 0;
    while (got < 10 && cyc < 40) begin
      if (res_valid) begin
        if (res_data !== exp_q[got] || res_core !== 2'(got % 4)) begin
          errors++; $display("FAIL bp_drain idx=%0d got core=%0d data=%h want core=%0d data=%h", got, res_core, res_data, got % 4, exp_q[got]);
        end
        checks++;
        got++;
      end
      tick(); cyc++;
    end
    if (got !== 10) begin errors++; $display("FAIL bp_drain_count got=%0d want=10", got); end
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_drained_valid got=%0b want=0", res_valid); end
    checks++;
  endtask

  task automatic test_halt();
    int got;
    int unsigned sc0;
    bit seen;
    sc0 = soup_count; got = 0; seen = 0;
    stop_on_life = 1'b1; soup_valid = 1'b1; res_ready = 1'b1; auto_life = 1; run_len = 6;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (soup_ready !== m_ready()) begin errors++; $display("FAIL halt_ready cyc=%0d got=%0b want=%0b", i, soup_ready, m_ready()); end
      checks++;
      if (halted && soup_ready !== 1'b0) begin errors++; $display("FAIL halt_ready_frozen got=%0b want=0", soup_ready); end
      if (halted) checks++;
      if (res_valid && res_ready) begin
        if (q_d.size() == 0 || res_data !== q_d[0] || res_core !== 2'(q_c[0])) begin
          errors++; $display("FAIL halt_report got core=%0d data=%h", res_core, res_data);
        end
        checks++;
        got++;
      end
      tick();
      if (halted !== m_halt) begin errors++; $display("FAIL halt_flag cyc=%0d got=%0b want=%0b", i, halted, m_halt); end
      checks++;
      if (halted) seen = 1;
    end
    if (!seen || halted !== 1'b1) begin errors++; $display("FAIL halt_set got=%0b want=1", halted); end
    checks++;
    if (got !== int'(soup_count - sc0)) begin errors++; $display("FAIL halt_collected got=%0d want=%0d", got, soup_count - sc0); end
    checks++;
    enable = 1'b0;
    tick();
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_release got=%0b want=0", halted); end
    checks++;
    enable = 1'b1; stop_on_life = 1'b0; soup_valid = 1'b0; auto_life = 0;
    repeat (5) tick();
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0; soup_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      core_data[i*R +: R] = rnd_rep();
      core_life = NCORE'(1) << i;
      tick();
    end
    soup_valid = 1'b1;
    tick(); tick();
    if (res_valid !== 1'b1 || q_d.size() !== 3) begin errors++; $display("FAIL mid_pre_fill got v=%0b n=%0d want v=1 n=3", res_valid, q_d.size()); end
    checks++;
    #2;
    reset = 1'b0;
    #1;
    if (soup_ready !== 1'b0 || core_run !== '0 || core_soup !== '0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_a got rdy=%0b run=%b soup=%h v=%0b", soup_ready, core_run, core_soup, res_valid);
    end
    checks++;
    if (res_core !== '0 || soup_count !== 32'd0 || drop_count !== 16'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL mid_reset_b got core=%0d sc=%0d dc=%0d h=%0b", res_core, soup_count, drop_count, halted);
    end
    checks++;
    cores_clear(); model_clear();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    if (core_run !== 4'b0001) begin errors++; $display("FAIL mid_restart_core got=%b want=0001", core_run); end
    checks++;
    if (soup_count !== 32'd1) begin errors++; $display("FAIL mid_restart_count got=%0d want=1", soup_count); end
    checks++;
    if (core_soup !== m_soup) begin errors++; $display("FAIL mid_restart_soup got=%h want=%h", core_soup, m_soup); end
    checks++;
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_simul_life();
    test_backpressure();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/soup_farm.md
# soup_farm

Multi-core dispatcher and result collector for the Life soup search. It accepts INIT×INIT random soups on a valid/ready stream and hands each one to an idle search core with a one-cycle run pulse. It captures each core's life report (soup, step count, bounding activity) into a result FIFO for the host. It generalises the single-core run/life flow to NCORE cores and adds backpressure, drop accounting and a stop-on-first-hit mode.

## Interface
- INIT, 20, soup edge length; soup width S = INIT*INIT
- NCORE, 4, number of search cores (1..16)
- DEPTH, 8, result FIFO entries (power of two, ≥2)
- R = S+64: report width {boundact[31:0], step_count[31:0], rng_init[S-1:0]}

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  dispatch permitted while high; falling edge clears halted
- stop_on_life  in  1  halt dispatch after first captured report
- soup_valid  in  1  soup offered
- soup_ready  out  1  soup accepted this cycle (valid&ready = handshake)
- soup_data  in  S  soup bits
- core_run  out  NCORE  one-cycle start pulse, one bit per core
- core_soup  out  S  registered soup, broadcast, held until next dispatch
- core_busy  in  NCORE  core k not in IDLE state
- core_life  in  NCORE  one-cycle life report pulse per core
- core_data  in  NCORE*R  report of core k at bits [k*R +: R]
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  host pops head when res_valid&res_ready
- res_data  out  R  FIFO head report
- res_core  out  clog2(NCORE) (min 1)  index of core that produced head
- soup_count  out  32  soups dispatched, wraps
- drop_count  out  16  reports lost, saturates at 16'hFFFF
- halted  out  1  stop_on_life hit, dispatch frozen

## Operation
- Per-core FSM: IDLE → ARMED on dispatch; ARMED → BUSY when core_busy[k]=1; BUSY → IDLE when core_busy[k]=0. ARMED never dispatches again.
- soup_ready = enable & ~halted & (any core IDLE), combinational.
- On a handshake, pick the first IDLE core at or after rr_ptr, wrapping. Register core_soup ← soup_data, pulse core_run[k], advance rr_ptr to k+1 mod NCORE, and increment soup_count.
- Report capture: core_life[k] latches its core_data slice into pend[k] and sets pv[k]. If pv[k] is already set, the new report is discarded and drop_count is incremented. Simultaneous pulses on different cores all capture.
- FIFO push: each cycle, if the FIFO is not full, move one pending slot into the FIFO. The slot is chosen round-robin from a separate push pointer. A pending slot is freed in the same cycle it is pushed.
- A push and a pop in the same cycle is legal, both when the FIFO is full and when it is empty-then-push. Occupancy stays consistent.
- Halt: if stop_on_life=1, any FIFO push sets halted. Cores already running finish and their reports are still collected. halted clears only on enable=0 or reset.
- Reset (any time, including mid-run): all FSMs return to IDLE, pending and FIFO are emptied, and counters and pointers clear. Reset does not drive the cores; they have their own reset.

## Timing
- Reset values: soup_ready 0, core_run 0, core_soup 0, res_valid 0, res_core 0, soup_count 0, drop_count 0, halted 0. res_data is don't-care while res_valid=0.
- Handshake at edge t → core_run[k]=1 and core_soup valid during cycle t+1. core_run is never high on two consecutive cycles for the same core.
- core_life[k] sampled at edge t → pend valid after t. The earliest push is at edge t+1, so res_valid is high after edge t+1 (2-cycle latency).
- FIFO is show-ahead: res_data and res_core update the cycle after a pop.
- Throughput: one dispatch per cycle and one push per cycle.

## Test plan
- NCORE=4, enable=1, soup_valid held, core_busy models 10-cycle runs → dispatch order cores 0,1,2,3. soup_ready drops until core 0 returns to IDLE. soup_count=4 after 4 handshakes. core_run pulses exactly 1 cycle after each handshake.
- core_life[1] and core_life[3] pulse in the same cycle, FIFO empty → both reports pop in round-robin order with res_core 1 then 3. res_valid first asserts 2 cycles after the pulse.
- res_ready=0 with DEPTH=8: inject 10 reports → 8 in FIFO, 2 held pending. A third report on a pending core → drop_count=1. Then res_ready=1 → 10 reports drain intact.
- stop_on_life=1: first report pushed → halted=1 and soup_ready=0 with soups still offered. Running cores' reports are still captured. Pull enable low → halted=0.
- Assert reset mid-run with 3 FIFO entries and 2 cores ARMED → every output takes its reset value immediately. After release, dispatch restarts at core 0 and soup_count restarts at 1.
